// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response and data-memory signals of the load/store unit
interface load_store_unit_if #(parameter int ADDR_WIDTH = 32);
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic [1:0] req_size;
  logic req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0] req_wdata;
  logic resp_valid;
  logic [31:0] resp_rdata;
  logic resp_error;
  logic mem_read_enable;
  logic mem_write_enable;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_data;
  modport slave (
    input req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_data,
    output req_ready, resp_valid, resp_rdata, resp_error,
           mem_read_enable, mem_write_enable, mem_address, mem_write_data
  );
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_data,
    input req_ready, resp_valid, resp_rdata, resp_error,
          mem_read_enable, mem_write_enable, mem_address, mem_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage sequencer for byte/half/word loads and stores on a word-organised memory
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input logic clk,
  input logic reset,
  load_store_unit_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LD_RD = 3'd1;
  localparam logic [2:0] LD_CAP = 3'd2;
  localparam logic [2:0] RMW_RD = 3'd3;
  localparam logic [2:0] RMW_CAP = 3'd4;
  localparam logic [2:0] ST_WR = 3'd5;
  localparam logic [2:0] ERR = 3'd6;
  logic [2:0] state;
  logic [2:0] state_nx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0] size_q;
  logic sgn_q;
  logic [31:0] wbuf;
  logic [31:0] rdata_q;
  logic err_q;
  logic valid_q;
  logic accept;
  logic is_word;
  logic is_half;
  logic misalign;
  logic [ADDR_WIDTH-1:0] addr_al;
  logic [4:0] sh;
  logic [31:0] lane;
  logic [31:0] ld_ext;
  logic [31:0] mask;
  logic [31:0] merged;
  logic rd;
  logic wr;
  assign accept = state == IDLE && bus.req_valid;
  assign is_word = bus.req_size[1];
  assign is_half = bus.req_size == 2'b01;
  assign misalign = CHECK_ALIGN && (is_word ? |bus.req_addr[1:0] : is_half & bus.req_addr[0]);
  assign addr_al = {bus.req_addr[ADDR_WIDTH-1:2],
                    is_word ? 2'b00 : {bus.req_addr[1], bus.req_addr[0] & ~is_half}};
  assign sh = {addr_q[1:0], 3'b000};
  assign lane = bus.mem_data >> sh;
  assign ld_ext = size_q[1] ? bus.mem_data :
                  size_q[0] ? {{16{sgn_q & lane[15]}}, lane[15:0]} :
                              {{24{sgn_q & lane[7]}}, lane[7:0]};
  assign mask = (size_q[0] ? 32'h0000_ffff : 32'h0000_00ff) << sh;
  assign merged = (bus.mem_data & ~mask) | ((wbuf << sh) & mask);
  assign rd = state == LD_RD || state == RMW_RD;
  assign wr = state == ST_WR;
  assign bus.req_ready = state == IDLE;
  assign bus.mem_read_enable = rd;
  assign bus.mem_write_enable = wr;
  assign bus.mem_address = (rd || wr) ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign bus.mem_write_data = wr ? wbuf : 32'd0;
  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_error = err_q;
  // next state: misaligned requests short-circuit to ERR, sub-word stores take the read-modify-write path
  always_comb begin
    state_nx = state == IDLE ? (bus.req_valid ? (misalign ? ERR :
                                                 !bus.req_write ? LD_RD :
                                                 is_word ? ST_WR : RMW_RD) : IDLE) :
               state == LD_RD ? LD_CAP :
               state == RMW_RD ? RMW_CAP :
               state == RMW_CAP ? ST_WR : IDLE;
  end
  // state, latched request, write buffer and held response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      addr_q <= '0;
      size_q <= 2'b00;
      sgn_q <= 1'b0;
      wbuf <= 32'd0;
      rdata_q <= 32'd0;
      err_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state <= state_nx;
      valid_q <= (accept && misalign) || state == LD_CAP || state == ST_WR;
      if (accept) begin
        addr_q <= addr_al;
        size_q <= is_word ? 2'b10 : bus.req_size;
        sgn_q <= bus.req_signed;
        wbuf <= bus.req_wdata;
      end
      if (state == RMW_CAP) wbuf <= merged;
      if (accept && misalign) begin
        rdata_q <= 32'd0;
        err_q <= 1'b1;
      end
      if (state == LD_CAP) begin
        rdata_q <= ld_ext;
        err_q <= 1'b0;
      end
      if (state == ST_WR) begin
        rdata_q <= 32'd0;
        err_q <= 1'b0;
      end
    end
  end
endmodule
